// File: rtl/mult_chk_pkg.sv
// Shared types and helpers for the exhaustive multiplier checker.
// Holds the FSM state type, default sizing and the reference product.
package mult_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int PROD_W    = 2 * DEF_WIDTH;
  localparam int NUM_VEC   = 2 ** (2 * DEF_WIDTH);

  // Widest operand exact_prod accepts; callers size-cast in and out.
  localparam int MAX_W = 16;

  function automatic logic [2*MAX_W-1:0] exact_prod(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    return {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
  endfunction

endpackage

// File: rtl/mult_exhaustive_checker_if.sv
// Operand/product bus between the checker and the multiplier under test.
// master: drives op_a/op_b, reads dut_p. slave: the multiplier side.
interface mult_chk_dut_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] dut_p;

  modport master (
    output op_a,
    output op_b,
    input  dut_p
  );

  modport slave (
    input  op_a,
    input  op_b,
    output dut_p
  );

endinterface

// File: rtl/mult_chk_pipe.sv
// LATENCY-deep delay line of {valid, a, b, expected} that lines each
// loaded vector up with the edge on which its DUT product is sampled.
// Ports: clk, rst_n (async low), i_* entry, o_* oldest stage.
module mult_chk_pipe #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [2*WIDTH-1:0] i_exp,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_b,
  output logic [2*WIDTH-1:0] o_exp
);

  localparam int DW = 1 + 4 * WIDTH;

  logic [DW-1:0] r_pipe [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {i_valid, i_a, i_b, i_exp};
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign {o_valid, o_a, o_b, o_exp} = r_pipe[LATENCY-1];

endmodule

// File: rtl/mult_exhaustive_checker.sv
// Sweeps every A,B pair into a multiplier and grades its products.
// Ports: clk, rst_n, start, bus (operands out / dut_p in), busy, done,
// pass, err_count, first_err_valid/a/b/p (first mismatch of the sweep).
module mult_exhaustive_checker
  import mult_chk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  mult_chk_dut_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic [2*WIDTH-1:0] first_err_p
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] LAST_IDX = '1;
  localparam logic [PW:0]   ERR_MAX  = {1'b1, {PW{1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]    r_idx;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [PW:0]      r_err;
  logic             r_fev;
  logic [WIDTH-1:0] r_fea;
  logic [WIDTH-1:0] r_feb;
  logic [PW-1:0]    r_fep;

  logic             w_load;
  logic             w_clear;
  logic [PW-1:0]    w_vec;
  logic [WIDTH-1:0] w_va;
  logic [WIDTH-1:0] w_vb;
  logic [PW-1:0]    w_exp;

  logic             w_cv;
  logic [WIDTH-1:0] w_ca;
  logic [WIDTH-1:0] w_cb;
  logic [PW-1:0]    w_ce;
  logic             w_mismatch;
  logic             w_last_cmp;

  // Vector to load this edge: 0 on a (re)start, else the next index.
  assign w_vec = w_clear ? '0 : r_idx + 1'b1;
  assign w_va  = w_vec[PW-1:WIDTH];
  assign w_vb  = w_vec[WIDTH-1:0];
  assign w_exp = PW'(exact_prod(MAX_W'(w_va), MAX_W'(w_vb)));

  mult_chk_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_load),
    .i_a     (w_va),
    .i_b     (w_vb),
    .i_exp   (w_exp),
    .o_valid (w_cv),
    .o_a     (w_ca),
    .o_b     (w_cb),
    .o_exp   (w_ce)
  );

  assign w_mismatch = w_cv && (bus.dut_p != w_ce);
  assign w_last_cmp = w_cv && ({w_ca, w_cb} == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_clear = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next  = RUN;
          w_load  = 1'b1;
          w_clear = 1'b1;
        end
      end
      RUN: begin
        w_load = 1'b1;
        if (w_vec == LAST_IDX) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_cmp) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_err  <= '0;
      r_fev  <= 1'b0;
      r_fea  <= '0;
      r_feb  <= '0;
      r_fep  <= '0;
    end else begin
      if (w_load) begin
        r_idx  <= w_vec;
        r_op_a <= w_va;
        r_op_b <= w_vb;
      end
      if (w_clear) begin
        r_err <= '0;
        r_fev <= 1'b0;
        r_fea <= '0;
        r_feb <= '0;
        r_fep <= '0;
      end else if (w_mismatch) begin
        if (r_err != ERR_MAX) begin
          r_err <= r_err + 1'b1;
        end
        if (!r_fev) begin
          r_fev <= 1'b1;
          r_fea <= w_ca;
          r_feb <= w_cb;
          r_fep <= bus.dut_p;
        end
      end
    end
  end

  assign bus.op_a = r_op_a;
  assign bus.op_b = r_op_b;

  assign busy            = (r_state == RUN) || (r_state == DRAIN);
  assign done            = (r_state == DONE);
  assign pass            = done && (r_err == '0);
  assign err_count       = r_err;
  assign first_err_valid = r_fev;
  assign first_err_a     = r_fea;
  assign first_err_b     = r_feb;
  assign first_err_p     = r_fep;

endmodule
